// File: rtl/cache_refill_writer.sv
// cache_refill_writer
//   Refill engine for the cache data array. A line-refill request (line index
//   plus critical-word offset) is turned into one wrapping burst read on the
//   memory side. Every returned beat is written straight into port A of the
//   data RAM in the same cycle it is accepted. The critical word (first beat)
//   is also forwarded to the pipeline as a registered one-cycle pulse.
//
// Ports
//   clk, rst           : clock and synchronous active-high reset
//   req_valid/ready    : refill request handshake (ready only while idle)
//   req_index/offset   : line to refill and critical-word offset
//   mem_ar*            : burst request (index + wrapping start offset)
//   mem_r*             : returned beats (rready only while collecting data)
//   ram_en/we/addr/din : data RAM port A write strobe, {line, word} address
//   crit_valid/data    : critical word, one cycle after its beat arrives
//   refill_done/err    : completion pulse, err flags an rlast mismatch
module cache_refill_writer #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int LINE_NUM       = 16,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE),
  localparam int IDX_W         = $clog2(LINE_NUM),
  localparam int ADDR_W        = IDX_W + OFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IDX_W-1:0]      req_index,
  input  logic [OFF_W-1:0]      req_offset,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [IDX_W-1:0]      mem_arindex,
  output logic [OFF_W-1:0]      mem_aroffset,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rlast,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data,
  output logic                  refill_done,
  output logic                  refill_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [OFF_W-1:0]      off_reg, off_next;
  logic [OFF_W-1:0]      cnt_reg, cnt_next;
  logic                  err_reg, err_next;
  logic                  crit_valid_reg, crit_valid_next;
  logic [DATA_WIDTH-1:0] crit_data_reg, crit_data_next;

  // OFF_W-bit sum wraps naturally inside the line.
  logic [OFF_W-1:0]      wr_off;
  logic                  is_last_beat;

  assign wr_off       = off_reg + cnt_reg;
  assign is_last_beat = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      off_reg        <= '0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      crit_valid_reg <= 1'b0;
      crit_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      off_reg        <= off_next;
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
      crit_valid_reg <= crit_valid_next;
      crit_data_reg  <= crit_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    off_next        = off_reg;
    cnt_next        = cnt_reg;
    err_next        = err_reg;
    crit_valid_next = 1'b0;
    crit_data_next  = crit_data_reg;

    req_ready   = 1'b0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    refill_done = 1'b0;
    refill_err  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          idx_next   = req_index;
          off_next   = req_offset;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = ST_ADDR;
        end
      end

      ST_ADDR: begin
        mem_arvalid = 1'b1;
        if (mem_arready) begin
          state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          // Beat goes to the RAM this very cycle; no write pipeline.
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == '0) begin
            crit_valid_next = 1'b1;
            crit_data_next  = mem_rdata;
          end
          // rlast must appear exactly on the final beat; anything else is
          // recorded, but the line is still filled with the full beat count.
          if (mem_rlast != is_last_beat) begin
            err_next = 1'b1;
          end
          if (is_last_beat) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // One dead cycle so port-B readers see the finished line before the
        // next refill can start.
        refill_done = 1'b1;
        refill_err  = err_reg;
        state_next  = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mem_arindex  = idx_reg;
  assign mem_aroffset = off_reg;
  assign ram_addr     = {idx_reg, wr_off};
  assign ram_din      = mem_rdata;
  assign crit_valid   = crit_valid_reg;
  assign crit_data    = crit_data_reg;

endmodule
